// File: rtl/mram_access_sequencer.sv
// mram_access_sequencer: turns single/burst commands into timed MRAM strobe sequences
module mram_access_sequencer #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 8,
  parameter int WR_CYC = 4,
  parameter int RD_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [1:0]        cmd_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mram_addr,
  output logic [DATA_W-1:0] mram_dq_out,
  output logic              mram_dq_oe,
  input  logic [DATA_W-1:0] mram_dq_in,
  output logic              chip_en,
  output logic              write_en,
  output logic              out_en,
  output logic              lower_byte_en,
  output logic              upper_byte_en
);
  typedef enum logic [2:0] {IDLE, SETUP, WR_PULSE, WR_HOLD, RD_ACCESS, RD_GAP, DONE} state_t;
  localparam logic [7:0] WR_LAST = 8'(WR_CYC - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_CYC - 1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic              write_q, write_d;
  logic [1:0]        be_q, be_d;
  logic [7:0]        cyc_q, cyc_d;
  logic [DATA_W-1:0] dq_q, dq_d;
  logic              oe_q, oe_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              in_burst;
  assign in_burst      = state_q != IDLE && state_q != DONE;
  assign cmd_ready     = state_q == IDLE;
  assign busy          = state_q != IDLE;
  assign done          = state_q == DONE;
  assign rd_valid      = state_q == RD_GAP;
  assign wr_ready      = state_q == SETUP && write_q && wr_valid;
  assign chip_en       = !in_burst;
  assign write_en      = state_q != WR_PULSE;
  assign out_en        = state_q != RD_ACCESS;
  assign lower_byte_en = !(in_burst && be_q[0]);
  assign upper_byte_en = !(in_burst && be_q[1]);
  assign mram_addr     = addr_q;
  assign mram_dq_out   = dq_q;
  assign mram_dq_oe    = oe_q;
  assign rd_data       = rd_q;
  // next-state: command latch, strobe phase timing, beat/address stepping
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beats_d = beats_q;
    write_d = write_q;
    be_d    = be_q;
    cyc_d   = cyc_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        addr_d  = cmd_addr;
        beats_d = cmd_len;
        write_d = cmd_write;
        be_d    = cmd_be;
        state_d = SETUP;
      end
      SETUP: begin
        cyc_d = '0;
        if (!write_q) state_d = RD_ACCESS;
        else if (wr_valid) begin
          dq_d    = wr_data;
          oe_d    = 1'b1;
          state_d = WR_PULSE;
        end
      end
      WR_PULSE: begin
        cyc_d   = cyc_q + 8'd1;
        state_d = cyc_q == WR_LAST ? WR_HOLD : WR_PULSE;
      end
      RD_ACCESS: begin
        cyc_d = cyc_q + 8'd1;
        if (cyc_q == RD_LAST) begin
          rd_d    = mram_dq_in;
          state_d = RD_GAP;
        end
      end
      WR_HOLD, RD_GAP: if (beats_q == '0) begin
        oe_d    = 1'b0;
        state_d = DONE;
      end else begin
        beats_d = beats_q - LEN_W'(1);
        addr_d  = addr_q + ADDR_W'(1);
        state_d = SETUP;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      cyc_q   <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      write_q <= write_d;
      be_q    <= be_d;
      cyc_q   <= cyc_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      rd_q    <= rd_d;
    end
  end
endmodule

// File: tb/tb_mram_access_sequencer.sv
// tb_mram_access_sequencer: transaction model plus per-cycle pin checks for the sequencer
module tb_mram_access_sequencer;
  localparam int WR_CYC = 4;
  localparam int RD_CYC = 3;
  typedef struct {logic [19:0] a; logic [15:0] d; logic [1:0] be;} wr_t;
  typedef struct {logic [15:0] d; int pre;} feed_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_write = 0, wr_valid, wr_ready;
  logic cmd_ready, rd_valid, busy, done, mram_dq_oe;
  logic chip_en, write_en, out_en, lower_byte_en, upper_byte_en;
  logic [19:0] cmd_addr = 0, mram_addr;
  logic [7:0] cmd_len = 0;
  logic [1:0] cmd_be = 0;
  logic [15:0] wr_data, rd_data, mram_dq_out, mram_dq_in = 0;
  int n_chk = 0, n_fail = 0, cyc_n = 0, ndone = 0, last_done = 0, acc = 0;
  wr_t exp_w[$];
  feed_t wq[$];
  logic [15:0] exp_r[$], rv_d[$];
  logic [19:0] exp_ra[$];
  int ws_t[$], rv_t[$];
  logic [15:0] ref_mem[logic [19:0]], dev_mem[logic [19:0]];
  logic [1:0] cur_be = 0;
  logic [15:0] wdat[4];

  mram_access_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .mram_addr(mram_addr), .mram_dq_out(mram_dq_out), .mram_dq_oe(mram_dq_oe), .mram_dq_in(mram_dq_in),
    .chip_en(chip_en), .write_en(write_en), .out_en(out_en),
    .lower_byte_en(lower_byte_en), .upper_byte_en(upper_byte_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [15:0] merge(logic [15:0] o, logic [15:0] d, logic [1:0] be);
    return {be[1] ? d[15:8] : o[15:8], be[0] ? d[7:0] : o[7:0]};
  endfunction
  function automatic logic [15:0] ref_rd(logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 16'h0;
  endfunction
  function automatic logic [15:0] dev_rd(logic [19:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : 16'h0;
  endfunction

  // write-beat source: presents queued beats, optionally withholding one for a number of cycles
  initial begin
    logic take;
    wr_valid = 0;
    wr_data = 0;
    forever begin
      @(negedge clk);
      if (wq.size() > 0 && wq[0].pre > 0) begin
        wq[0].pre = wq[0].pre - 1;
        wr_valid = 0;
      end else begin
        wr_valid = wq.size() > 0;
        wr_data = wq.size() > 0 ? wq[0].d : 16'h0;
      end
      #2 take = wr_ready;
      @(posedge clk);
      if (take && wq.size() > 0) wq.delete(0);
    end
  end

  // MRAM device model and per-cycle compare against the transaction expectations
  initial begin
    int wlow, rlow;
    logic [19:0] wa;
    logic [15:0] wd;
    wr_t e;
    wlow = 0;
    rlow = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        wlow = 0;
        rlow = 0;
      end else begin
        mram_dq_in = dev_rd(mram_addr);
        chk("we_oe_overlap", {31'd0, !write_en && !out_en}, 0);
        chk("oe_while_dq_driven", {31'd0, !out_en && mram_dq_oe}, 0);
        chk("byte_en", {30'd0, upper_byte_en, lower_byte_en}, chip_en ? 32'd3 : {30'd0, ~cur_be});
        if (!write_en) begin
          if (wlow == 0) begin
            ws_t.push_back(cyc_n);
            wa = mram_addr;
            wd = mram_dq_out;
          end
          wlow++;
          chk("dq_oe_in_pulse", {31'd0, mram_dq_oe}, 1);
          chk("cs_in_pulse", {31'd0, chip_en}, 0);
        end else if (wlow > 0) begin
          chk("wr_pulse_len", wlow, WR_CYC);
          chk("wr_addr_held", {12'd0, mram_addr}, {12'd0, wa});
          chk("wr_dq_held", {16'd0, mram_dq_out}, {16'd0, wd});
          chk("wr_unexpected", exp_w.size() > 0, 1);
          if (exp_w.size() > 0) begin
            e = exp_w.pop_front();
            chk("wr_addr", {12'd0, wa}, {12'd0, e.a});
            chk("wr_data", {16'd0, wd}, {16'd0, e.d});
          end
          dev_mem[wa] = merge(dev_rd(wa), wd, {~upper_byte_en, ~lower_byte_en});
          wlow = 0;
        end
        if (!out_en) rlow++;
        else if (rlow > 0) begin
          chk("rd_access_len", rlow, RD_CYC);
          rlow = 0;
        end
        if (rd_valid) begin
          rv_t.push_back(cyc_n);
          rv_d.push_back(rd_data);
          chk("rd_unexpected", exp_r.size() > 0, 1);
          if (exp_r.size() > 0) begin
            chk("rd_data", {16'd0, rd_data}, {16'd0, exp_r.pop_front()});
            chk("rd_addr", {12'd0, mram_addr}, {12'd0, exp_ra.pop_front()});
          end
        end
        if (done) begin
          ndone++;
          last_done = cyc_n;
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [19:0] a, input int len, input logic [1:0] be, input int stall);
    logic [19:0] x;
    for (int i = 0; i <= len; i++) begin
      x = a + 20'(i);
      if (wr) begin
        wq.push_back('{wdat[i], (i == stall) ? 8 : 0});
        exp_w.push_back('{x, wdat[i], be});
        ref_mem[x] = merge(ref_rd(x), wdat[i], be);
      end else begin
        exp_r.push_back(ref_rd(x));
        exp_ra.push_back(x);
      end
    end
    @(negedge clk);
    cmd_write = wr;
    cmd_addr = a;
    cmd_len = 8'(len);
    cmd_be = be;
    cmd_valid = 1;
    cur_be = be;
    #1 chk("cmd_ready_idle", {31'd0, cmd_ready}, 1);
    @(posedge clk);
    #1 acc = cyc_n;
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int nb);
    int i;
    i = 0;
    while (ndone == nb && i < 400) begin
      @(negedge clk);
      #3 i++;
    end
    chk("done_seen", {31'd0, ndone != nb}, 1);
    @(negedge clk);
    #3;
  endtask

  initial begin
    int b, nd;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b, nd;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobes", {27'd0, chip_en, write_en, out_en, lower_byte_en, upper_byte_en}, 32'h1f);
    chk("rst_oe", {31'd0, mram_dq_oe}, 0);
    chk("rst_addr", {12'd0, mram_addr}, 0);
    chk("rst_dq_out", {16'd0, mram_dq_out}, 0);
    chk("rst_rd_data", {16'd0, rd_data}, 0);
    chk("rst_flags", {28'd0, rd_valid, wr_ready, done, busy}, 0);
    rst = 0;
    #1 chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 1);

    wdat[0] = 16'hA5C3;
    b = ws_t.size();
    nd = ndone;
    issue(1, 20'h00010, 0, 2'b11, -1);
    chk("busy_after_accept", {31'd0, busy}, 1);
    wait_done(nd);
    chk("wr1_done_latency", last_done - acc + 1, 7);
    chk("wr1_pulse_start", ws_t[b] - acc + 1, 2);
    chk("wr1_mem", {16'd0, dev_rd(20'h00010)}, 32'hA5C3);
    chk("busy_after_done", {31'd0, busy}, 0);

    dev_mem[20'h11] = 16'h1111; ref_mem[20'h11] = 16'h1111;
    dev_mem[20'h12] = 16'h2222; ref_mem[20'h12] = 16'h2222;
    dev_mem[20'h13] = 16'h3333; ref_mem[20'h13] = 16'h3333;
    b = rv_t.size();
    nd = ndone;
    issue(0, 20'h00010, 3, 2'b11, -1);
    wait_done(nd);
    chk("rd_beats", rv_t.size() - b, 4);
    chk("rd_first_latency", rv_t[b] - acc + 1, 5);
    for (int i = 0; i < 3; i++) chk("rd_spacing", rv_t[b+i+1] - rv_t[b+i], 5);
    chk("rd_beat0", {16'd0, rv_d[b]}, 32'hA5C3);
    chk("rd_beat3", {16'd0, rv_d[b+3]}, 32'h3333);
    chk("rd_done_count", ndone - nd, 1);
    chk("rd_done_latency", last_done - acc + 1, 21);

    wdat[0] = 16'h1001; wdat[1] = 16'h2002; wdat[2] = 16'h3003; wdat[3] = 16'h4004;
    b = ws_t.size();
    nd = ndone;
    issue(1, 20'h00020, 3, 2'b11, 1);
    wait_done(nd);
    chk("stall_spacing", ws_t[b+1] - ws_t[b], 9);
    chk("post_stall_spacing", ws_t[b+2] - ws_t[b+1], 6);
    chk("stall_mem1", {16'd0, dev_rd(20'h00021)}, 32'h2002);
    chk("stall_mem3", {16'd0, dev_rd(20'h00023)}, 32'h4004);
    chk("stall_drained", exp_w.size(), 0);

    wdat[0] = 16'h0001; wdat[1] = 16'h0002; wdat[2] = 16'h0003; wdat[3] = 16'h0004;
    nd = ndone;
    issue(1, 20'hFFFFE, 3, 2'b11, -1);
    wait_done(nd);
    chk("wrap_fffff", {16'd0, dev_rd(20'hFFFFF)}, 32'h0002);
    chk("wrap_00000", {16'd0, dev_rd(20'h00000)}, 32'h0003);
    chk("wrap_00001", {16'd0, dev_rd(20'h00001)}, 32'h0004);

    dev_mem[20'h30] = 16'hBEEF; ref_mem[20'h30] = 16'hBEEF;
    wdat[0] = 16'h1234;
    nd = ndone;
    issue(1, 20'h00030, 0, 2'b01, -1);
    wait_done(nd);
    chk("be01_mem", {16'd0, dev_rd(20'h00030)}, 32'hBE34);

    wdat[0] = 16'hAAAA; wdat[1] = 16'hBBBB;
    b = ws_t.size();
    nd = ndone;
    issue(1, 20'h00040, 1, 2'b11, -1);
    for (int i = 0; i < 100 && ws_t.size() < b + 2; i++) begin
      @(negedge clk);
      #3;
    end
    chk("beat2_pulse_seen", {31'd0, ws_t.size() >= b + 2}, 1);
    #1 rst = 1;
    #1;
    chk("abort_strobes", {30'd0, write_en, chip_en}, 3);
    chk("abort_oe", {31'd0, mram_dq_oe}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    @(negedge clk);
    #4 rst = 0;
    exp_w.delete();
    wq.delete();
    #1 chk("abort_cmd_ready", {31'd0, cmd_ready}, 1);
    repeat (10) @(negedge clk);
    #3;
    chk("abort_no_done", ndone - nd, 0);
    chk("abort_beat1_mem", {16'd0, dev_rd(20'h00040)}, 32'hAAAA);
    chk("abort_beat2_mem", {16'd0, dev_rd(20'h00041)}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
